// File: rtl/card_flip_renderer_if.sv
// card_flip_renderer_if
// Bundles the per-card pixel query, command pulses and status/hit outputs of
// one card slot. The game/video side drives through the master modport, the
// card renderer sits on the slave modport.
//   x, y            current pixel column/row
//   pos_x, pos_y    card left edge (full width) and top edge
//   symbol_sel      symbol shape shown on the face
//   selected        cursor is on this card
//   frame_tick      one-cycle pulse per video frame
//   flip_up/flip_down/match/clear  command pulses
//   incard/inface/insymbol/inborder  registered pixel hit flags
//   face_up/matched/busy/done        registered card status
interface card_flip_renderer_if;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [2:0] symbol_sel;
  logic       selected;
  logic       frame_tick;
  logic       flip_up;
  logic       flip_down;
  logic       match;
  logic       clear;
  logic       incard;
  logic       inface;
  logic       insymbol;
  logic       inborder;
  logic       face_up;
  logic       matched;
  logic       busy;
  logic       done;

  modport master (
    output x, y, pos_x, pos_y, symbol_sel, selected, frame_tick,
           flip_up, flip_down, match, clear,
    input  incard, inface, insymbol, inborder, face_up, matched, busy, done
  );

  modport slave (
    input  x, y, pos_x, pos_y, symbol_sel, selected, frame_tick,
           flip_up, flip_down, match, clear,
    output incard, inface, insymbol, inborder, face_up, matched, busy, done
  );
endinterface

// File: rtl/card_flip_renderer.sv
// card_flip_renderer
// One memory-game card: holds its state (down / flipping / up / matched),
// animates flips by shrinking the half-width to zero, swapping the visible
// side, and growing it back one STEP per frame_tick, and produces registered
// per-pixel hit flags for the colour mux.
// Ports:
//   clk    pixel clock
//   rst_n  synchronous active-low reset
//   bus    card_flip_renderer_if.slave (pixel query, commands, hit/status outputs)
module card_flip_renderer #(
  parameter int CARD_W   = 50,
  parameter int CARD_H   = 70,
  parameter int STEP     = 5,
  parameter int BORDER   = 3,
  parameter int SYM_SIZE = 30,
  parameter int SYM_T    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  card_flip_renderer_if.slave   bus
);

  localparam int HALF = CARD_W / 2;
  localparam int HS   = SYM_SIZE / 2;
  localparam int TT   = SYM_T + 1;
  localparam int HASH_OFF = HS / 3;
  localparam int R_OUT2 = HS * HS;
  localparam int R_IN2  = (HS - SYM_T) * (HS - SYM_T);

  localparam logic [9:0] HALF_V   = 10'(HALF);
  localparam logic [9:0] STEP_V   = 10'(STEP);
  localparam logic [9:0] CARD_H_V = 10'(CARD_H);
  localparam logic [9:0] BORDER_V = 10'(BORDER);
  localparam logic [9:0] SYM_CY_V = 10'(CARD_H / 2);

  typedef enum logic [2:0] {
    S_DOWN      = 3'd0,
    S_SHRINK_UP = 3'd1,
    S_GROW_UP   = 3'd2,
    S_UP        = 3'd3,
    S_SHRINK_DN = 3'd4,
    S_GROW_DN   = 3'd5,
    S_MATCHED   = 3'd6
  } state_t;

  // Symbol shape hit test on signed offsets from the symbol centre.
  function automatic logic sym_hit(input logic [2:0] sel,
                                   input logic signed [11:0] dxs,
                                   input logic signed [11:0] dys);
    int dx, dy, ax, ay, d, r2, t;
    logic box, hit;
    dx  = int'(dxs);
    dy  = int'(dys);
    ax  = (dx < 32'sd0) ? -dx : dx;
    ay  = (dy < 32'sd0) ? -dy : dy;
    d   = (ax > ay) ? (ax - ay) : (ay - ax);
    r2  = dx * dx + dy * dy;
    box = (ax < HS) && (ay < HS);
    t   = 32'sd0;
    case (sel)
      3'd0: hit = box && (((ax + ax) < SYM_T) || ((ay + ay) < SYM_T));
      3'd1: hit = box && ((ay + ay) < SYM_T);
      3'd2: hit = box && ((d + d) < SYM_T);
      3'd3: hit = box && ((ax >= HS - SYM_T) || (ay >= HS - SYM_T));
      3'd4: begin
        hit = box && ((((ax > HASH_OFF) ? ax - HASH_OFF : HASH_OFF - ax) * 2 < SYM_T) ||
                      (((ay > HASH_OFF) ? ay - HASH_OFF : HASH_OFF - ay) * 2 < SYM_T));
      end
      3'd5: hit = (r2 < R_OUT2) && (r2 >= R_IN2);
      3'd6: begin
        // apex at the top: row width grows with distance from the top
        t   = dy + HS;
        hit = box && ((ax + ax) <= t) && ((t >= 2 * HS - TT) || ((ax + ax) > t - 2 * TT));
      end
      3'd7: begin
        t   = HS - dy;
        hit = box && ((ax + ax) <= t) && ((t >= 2 * HS - TT) || ((ax + ax) > t - 2 * TT));
      end
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  state_t     state_r;
  logic [9:0] hw_r;
  logic       side_r;      // 1 = face visible, 0 = back visible
  logic       busy_r;
  logic       done_r;
  logic       face_up_r;
  logic       matched_r;
  logic       incard_r;
  logic       inface_r;
  logic       insymbol_r;
  logic       inborder_r;

  logic [9:0] cx_s;
  logic [9:0] left_s;
  logic [9:0] right_s;
  logic [9:0] bottom_s;
  logic [9:0] sy_s;
  logic       incard_s;
  logic       edge_s;
  logic       sym_s;
  logic signed [11:0] dx_s;
  logic signed [11:0] dy_s;
  logic [9:0] shrink_hw_s;
  logic [9:0] grow_hw_s;

  // Animated card geometry, symbol offsets and next half-width candidates.
  always_comb begin
    cx_s     = bus.pos_x + HALF_V;
    left_s   = cx_s - hw_r;
    right_s  = cx_s + hw_r;
    bottom_s = bus.pos_y + CARD_H_V;
    sy_s     = bus.pos_y + SYM_CY_V;
    incard_s = (bus.y >= bus.pos_y) && (bus.y < bottom_s) &&
               (bus.x >= left_s) && (bus.x < right_s);
    edge_s   = (bus.x < left_s + BORDER_V) || (bus.x >= right_s - BORDER_V) ||
               (bus.y < bus.pos_y + BORDER_V) || (bus.y >= bottom_s - BORDER_V);
    dx_s     = $signed({2'b00, bus.x}) - $signed({2'b00, cx_s});
    dy_s     = $signed({2'b00, bus.y}) - $signed({2'b00, sy_s});
    sym_s    = sym_hit(bus.symbol_sel, dx_s, dy_s);
    if (hw_r > STEP_V) begin
      shrink_hw_s = hw_r - STEP_V;
    end else begin
      shrink_hw_s = 10'd0;
    end
    if (hw_r + STEP_V >= HALF_V) begin
      grow_hw_s = HALF_V;
    end else begin
      grow_hw_s = hw_r + STEP_V;
    end
  end

  // Card state machine: commands, frame-stepped animation, busy/done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_DOWN;
      hw_r    <= HALF_V;
      side_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.clear) begin
        state_r <= S_DOWN;
        hw_r    <= HALF_V;
        side_r  <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          S_DOWN: begin
            if (bus.flip_up) begin
              state_r <= S_SHRINK_UP;
              busy_r  <= 1'b1;
            end
          end
          S_UP: begin
            if (bus.match) begin
              state_r <= S_MATCHED;
            end else if (bus.flip_down) begin
              state_r <= S_SHRINK_DN;
              busy_r  <= 1'b1;
            end
          end
          S_SHRINK_UP, S_SHRINK_DN: begin
            if (bus.frame_tick) begin
              hw_r <= shrink_hw_s;
              if (shrink_hw_s == 10'd0) begin
                side_r  <= ~side_r;
                state_r <= (state_r == S_SHRINK_UP) ? S_GROW_UP : S_GROW_DN;
              end
            end
          end
          S_GROW_UP, S_GROW_DN: begin
            if (bus.frame_tick) begin
              hw_r <= grow_hw_s;
              if (grow_hw_s == HALF_V) begin
                state_r <= (state_r == S_GROW_UP) ? S_UP : S_DOWN;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end
            end
          end
          S_MATCHED: begin
            state_r <= S_MATCHED;
          end
          default: begin
            state_r <= S_DOWN;
            hw_r    <= HALF_V;
            side_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Face/matched status, one cycle behind the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      face_up_r <= 1'b0;
      matched_r <= 1'b0;
    end else begin
      face_up_r <= (state_r == S_UP) || (state_r == S_MATCHED);
      matched_r <= (state_r == S_MATCHED);
    end
  end

  // Registered pixel hit flags; the symbol only shows on a fully open face.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      incard_r   <= 1'b0;
      inface_r   <= 1'b0;
      insymbol_r <= 1'b0;
      inborder_r <= 1'b0;
    end else begin
      incard_r   <= incard_s;
      inface_r   <= incard_s & side_r;
      insymbol_r <= sym_s & side_r & (hw_r == HALF_V);
      inborder_r <= bus.selected & incard_s & edge_s;
    end
  end

  assign bus.incard   = incard_r;
  assign bus.inface   = inface_r;
  assign bus.insymbol = insymbol_r;
  assign bus.inborder = inborder_r;
  assign bus.face_up  = face_up_r;
  assign bus.matched  = matched_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_card_flip_renderer.sv
module tb_card_flip_renderer;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  int done_cnt;

  card_flip_renderer_if bus ();

  card_flip_renderer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hw_exp[10];
    hw_exp = '{20, 15, 10, 5, 0, 5, 10, 15, 20, 25};

    rst_n = 1'b0;
    bus.x = 10'd125; bus.y = 10'd85;
    bus.pos_x = 10'd100; bus.pos_y = 10'd50;
    bus.symbol_sel = 3'd0; bus.selected = 1'b0;
    bus.frame_tick = 1'b0; bus.flip_up = 1'b0; bus.flip_down = 1'b0;
    bus.match = 1'b0; bus.clear = 1'b0;
    tick(); tick();
    chk("rst_incard", bus.incard, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_face_up", bus.face_up, 0);
    chk("rst_done", bus.done, 0);

    // first pixel after reset, face down at full width
    rst_n = 1'b1;
    tick();
    chk("down_incard", bus.incard, 1);
    chk("down_inface", bus.inface, 0);
    chk("down_insymbol", bus.insymbol, 0);
    chk("down_face_up", bus.face_up, 0);
    chk("down_busy", bus.busy, 0);

    // reveal animation
    bus.flip_up = 1'b1;
    tick();
    bus.flip_up = 1'b0;
    chk("flip_busy", bus.busy, 1);
    chk("flip_hw_hold", dut.hw_r, 25);
    for (int i = 0; i < 10; i++) begin
      frame();
      chk($sformatf("up_hw%0d", i), dut.hw_r, hw_exp[i]);
      chk($sformatf("up_done%0d", i), bus.done, (i == 9) ? 1 : 0);
      chk($sformatf("up_busy%0d", i), bus.busy, (i == 9) ? 0 : 1);
      if (i == 2) begin
        bus.x = 10'd114;
        tick();
        chk("mid_incard_114", bus.incard, 0);
        bus.x = 10'd115;
        tick();
        chk("mid_incard_115", bus.incard, 1);
        bus.x = 10'd125;
        tick();
        chk("mid_insymbol", bus.insymbol, 0);
      end
      if (i == 4) begin
        tick();
        chk("zero_incard", bus.incard, 0);
      end
      tick();
      chk($sformatf("up_done_gap%0d", i), bus.done, 0);
    end
    chk("up_face_up", bus.face_up, 1);
    chk("up_inface", bus.inface, 1);
    chk("up_insymbol", bus.insymbol, 1);

    // match beats flip_down, then matched is terminal until clear
    bus.match = 1'b1; bus.flip_down = 1'b1;
    tick();
    bus.match = 1'b0; bus.flip_down = 1'b0;
    tick();
    chk("m_matched", bus.matched, 1);
    chk("m_face_up", bus.face_up, 1);
    chk("m_busy", bus.busy, 0);
    bus.flip_down = 1'b1;
    tick();
    bus.flip_down = 1'b0;
    tick();
    chk("m_ign_busy", bus.busy, 0);
    chk("m_ign_matched", bus.matched, 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_done", bus.done, 0);
    chk("clr_hw", dut.hw_r, 25);
    tick();
    chk("clr_matched", bus.matched, 0);
    chk("clr_face_up", bus.face_up, 0);
    chk("clr_inface", bus.inface, 0);
    chk("clr_done2", bus.done, 0);

    // flip_up with frame_tick in the same cycle; commands while busy ignored
    bus.flip_up = 1'b1; bus.frame_tick = 1'b1;
    tick();
    bus.flip_up = 1'b0; bus.frame_tick = 1'b0;
    chk("acc_hw_hold", dut.hw_r, 25);
    chk("acc_busy", bus.busy, 1);
    bus.flip_down = 1'b1;
    tick();
    bus.flip_down = 1'b0;
    bus.flip_up = 1'b1;
    tick();
    bus.flip_up = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      frame();
      if (bus.done === 1'b1) done_cnt++;
      chk($sformatf("b_busy%0d", i), bus.busy, (i == 9) ? 0 : 1);
      chk($sformatf("b_hw%0d", i), dut.hw_r, hw_exp[i]);
    end
    tick();
    chk("b_done_cnt", done_cnt, 1);
    chk("b_face_up", bus.face_up, 1);
    chk("b_insymbol", bus.insymbol, 1);

    // reset in the middle of GROW_UP
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.flip_up = 1'b1;
    tick();
    bus.flip_up = 1'b0;
    for (int i = 0; i < 6; i++) frame();
    chk("g_hw5", dut.hw_r, 5);
    chk("g_busy", bus.busy, 1);
    rst_n = 1'b0;
    tick();
    chk("r_hw", dut.hw_r, 25);
    chk("r_busy", bus.busy, 0);
    chk("r_incard", bus.incard, 0);
    chk("r_inface", bus.inface, 0);
    chk("r_face_up", bus.face_up, 0);
    chk("r_done", bus.done, 0);
    rst_n = 1'b1;
    bus.selected = 1'b1;
    bus.x = 10'd100; bus.y = 10'd50;
    tick();
    chk("bd_corner", bus.inborder, 1);
    chk("bd_corner_incard", bus.incard, 1);
    bus.x = 10'd103; bus.y = 10'd53;
    tick();
    chk("bd_inner", bus.inborder, 0);
    chk("bd_inner_incard", bus.incard, 1);
    bus.x = 10'd149;
    tick();
    chk("bd_right", bus.inborder, 1);
    bus.x = 10'd150;
    tick();
    chk("bd_outside", bus.incard, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/card_flip_renderer.md
Name: card_flip_renderer

Overview:
- Parametrised, clocked successor to the static card/symbol pixel generator used by the memory-game VGA renderer.
- Holds one card's game state: face-down, flipping, face-up, or matched.
- Animates flips by shrinking the card's half-width to zero and growing it back, stepping once per video frame.
- Emits registered per-pixel hit flags (card body, face, symbol, selection border) for the colour mux.
- The top level instantiates one per card slot.

Parameters:
CARD_W, 50, card width in pixels (must be even)
CARD_H, 70, card height in pixels
STEP, 5, half-width change per frame_tick during animation (1..CARD_W/2)
BORDER, 3, selection frame thickness in pixels, drawn inside the card edge
SYM_SIZE, 30, symbol length passed to the symbol generators
SYM_T, 4, symbol line thickness (triangle generators use SYM_T+1)

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
x  in  10  current pixel column
y  in  10  current pixel row
pos_x  in  10  card left edge at full width
pos_y  in  10  card top edge
symbol_sel  in  3  0 plus, 1 minus, 2 cross, 3 square, 4 hash, 5 circle, 6 triangle, 7 inverted triangle
selected  in  1  cursor is on this card (enables border)
frame_tick  in  1  one-cycle pulse per frame; animation advances only on it
flip_up  in  1  command pulse: reveal
flip_down  in  1  command pulse: hide
match  in  1  command pulse: lock face-up
clear  in  1  command pulse: return to face-down immediately
incard  out  1  pixel inside animated card rectangle
inface  out  1  incard and visible side is the face
insymbol  out  1  face fully open and pixel on symbol
inborder  out  1  selected, incard, and within BORDER of the animated edge
face_up  out  1  state UP or MATCHED
matched  out  1  state MATCHED
busy  out  1  animation in progress
done  out  1  one-cycle pulse when an animation completes

Behaviour:
- Reset is synchronous on rst_n=0 at a clk edge, in any state including mid-animation:
  - state=DOWN, hw=HALF (HALF=CARD_W/2), side=BACK.
  - All outputs 0.
- Geometry:
  - cx = pos_x + HALF.
  - incard = (y >= pos_y) & (y < pos_y+CARD_H) & (x >= cx-hw) & (x < cx+hw).
  - hw=0 gives incard=0.
  - Symbol centre is (pos_x+HALF, pos_y+CARD_H/2).
  - All arithmetic is 10-bit unsigned; cards must not straddle 0 or 1023.
- Pixel outputs are registered: x/y/pos at cycle n appear on incard/inface/insymbol/inborder at cycle n+1.
  - insymbol = symbol hit & side==FACE & hw==HALF.
  - inborder = selected & incard & (x < cx-hw+BORDER | x >= cx+hw-BORDER | y < pos_y+BORDER | y >= pos_y+CARD_H-BORDER).
- States: DOWN, SHRINK_UP, GROW_UP, UP, SHRINK_DN, GROW_DN, MATCHED.
- Transitions (evaluated every clk):
  - DOWN + flip_up -> SHRINK_UP.
  - UP + match -> MATCHED. Match has priority over flip_down in the same cycle.
  - UP + flip_down -> SHRINK_DN.
  - SHRINK_x on frame_tick: hw <= (hw>STEP) ? hw-STEP : 0. When the new hw is 0, toggle side and go to GROW_x.
  - GROW_x on frame_tick: hw <= min(hw+STEP, HALF). When the new hw is HALF, go to UP (from GROW_UP) or DOWN (from GROW_DN) and assert done for exactly that cycle.
  - MATCHED is terminal, left only by clear or reset.
  - clear from any state -> DOWN, hw=HALF, side=BACK, next cycle; no done pulse. clear outranks all other commands.
- Command acceptance:
  - Commands not legal in the current state are ignored and not queued. This includes flip_up/flip_down/match while busy, and flip_up while UP.
  - A command accepted in the same cycle as frame_tick changes state only; hw starts moving on the next frame_tick.
- busy = state in {SHRINK_UP, GROW_UP, SHRINK_DN, GROW_DN}.
- face_up and matched are registered from state and change one cycle after the transition edge.
- Animation length is 2*ceil(HALF/STEP) frame_ticks. The defaults give 5 shrink + 5 grow = 10.

Test Plan:
- Reset, pos=(100,50), pixel (125,85) -> one cycle later incard=1, inface=0, insymbol=0, face_up=0, busy=0.
- flip_up, then 10 frame_ticks -> hw steps 20,15,10,5,0 then 5,10,15,20,25. busy=1 throughout. done pulses once with the 10th tick. face_up=1. symbol_sel=0 pixel (125,85) gives insymbol=1.
- Mid-animation at hw=10, probe x=114 and x=115 (cx=125) -> incard 0 and 1 respectively. insymbol=0 even on symbol pixels.
- In UP, assert match and flip_down together -> MATCHED, matched=1, face_up=1. A later flip_down is ignored. clear -> DOWN, hw=25, no done.
- flip_up accepted, then flip_down and a second flip_up issued while busy -> both ignored; animation ends in UP after exactly 10 ticks.
- rst_n=0 at hw=5 in GROW_UP -> next cycle DOWN, hw=25, all outputs 0. selected=1 then gives inborder=1 at (100,50) and 0 at (103,53).
